// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Inter-stage pipeline register for the pipelined CPU (IF/ID, ID/EX, EX/MEM,
//   MEM/WB). Moves a control bundle and a datapath bundle through DEPTH slots.
//   Each slot carries a valid bit. The register supports stall (hold every slot)
//   and flush (turn every slot into a bubble). All state updates on the rising
//   edge of clk_i. Reset is synchronous and active-high.
//
//   Optional feature: define PIPE_STAGE_STATS_EN to build two saturating
//   statistics counters (stall cycles and bubble cycles). Without the macro,
//   those counters are not built and both count outputs read 0.
//
// Parameters
//   DATA_W : datapath bundle width
//   CTRL_W : control bundle width
//   DEPTH  : number of slots in series (1..8)
//   CNT_W  : statistics counter width
//
// Ports
//   clk_i        : clock
//   rst_i        : synchronous reset, active-high
//   stall_i      : hold all slots this cycle
//   flush_i      : invalidate all slots this cycle (wins over stall_i)
//   valid_i      : the input bundle is a real instruction
//   ctrl_i       : control bundle in
//   data_i       : datapath bundle in
//   valid_o      : valid bit of the last slot
//   ctrl_o       : control bundle of the last slot (0 whenever valid_o = 0)
//   data_o       : datapath bundle of the last slot
//   stall_cnt_o  : cycles held by stall (statistics build only)
//   bubble_cnt_o : cycles where the last slot is a bubble after the update
//                  (statistics build only)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 4,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam int LAST = DEPTH - 1;

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH must be in 1..8");
    end

    // Slot state, where index k is slot s[k].
    logic [DEPTH-1:0]             v_q;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q;
    logic [DEPTH-1:0][DATA_W-1:0] data_q;

    // This is the value that each slot loads when the pipe advances.
    logic [DEPTH-1:0]             src_v;
    logic [DEPTH-1:0][CTRL_W-1:0] src_ctrl;
    logic [DEPTH-1:0][DATA_W-1:0] src_data;

    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_src
        if (gi == 0) begin : g_head
            // The control bundle is gated by valid_i. A bubble therefore never
            // carries a write enable. The data is captured unconditionally.
            assign src_v[gi]    = valid_i;
            assign src_ctrl[gi] = valid_i ? ctrl_i : '0;
            assign src_data[gi] = data_i;
        end else begin : g_body
            assign src_v[gi]    = v_q[gi-1];
            assign src_ctrl[gi] = ctrl_q[gi-1];
            assign src_data[gi] = data_q[gi-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v_q    <= '0;
            ctrl_q <= '0;
            data_q <= '0;
        end else if (flush_i) begin
            // Flush keeps the data fields. Only v and ctrl must be cleared to
            // keep the bubble invariant.
            v_q    <= '0;
            ctrl_q <= '0;
        end else if (!stall_i) begin
            v_q    <= src_v;
            ctrl_q <= src_ctrl;
            data_q <= src_data;
        end
    end

    assign valid_o = v_q[LAST];
    assign ctrl_o  = ctrl_q[LAST];
    assign data_o  = data_q[LAST];

`ifdef PIPE_STAGE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             last_v_d;

    // This is the valid bit that the last slot will hold after this edge. It
    // decides if the edge counts as a bubble cycle.
    always_comb begin
        last_v_d = v_q[LAST];
        if (flush_i) begin
            last_v_d = 1'b0;
        end else if (!stall_i) begin
            last_v_d = src_v[LAST];
        end
    end

    // The counters saturate at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (!flush_i && stall_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (!last_v_d && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`else
    assign stall_cnt_o  = '0;
    assign bubble_cnt_o = '0;
`endif

`ifndef SYNTHESIS
    // Unknown values on the handshake inputs would corrupt every slot silently.
    always @(posedge clk_i) begin
        if (!rst_i && $isunknown({stall_i, flush_i, valid_i})) begin
            $error("pipe_stage_reg: X on stall_i/flush_i/valid_i");
        end
    end
`endif

endmodule
